p2_pool_write: RTL and testbench

//  Pooling-2 stage: 2x2/stride-2 signed max-pool of the 12 conv-2 feature maps (8x8 each)

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/p2_pool_write_if.sv | 23 ++
 rtl/p2_pool_write_max_acc.sv | 33 +++
 rtl/p2_pool_write.sv | 134 +++++++++++++
 tb/tb_p2_pool_write.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath parameters, feature-value type and pooling FSM state encoding.
package cnn_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IMG_W    = 8;
  localparam int unsigned CHANNELS = 12;
  localparam int unsigned P2_W     = IMG_W / 2;
  localparam int unsigned C2_AW    = 6;
  localparam int unsigned P2_AW    = 4;
  localparam int unsigned CH_W     = 4;
  localparam int unsigned TAP_W    = 2;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAST = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } pool_state_e;

endpackage

// File: rtl/p2_pool_write_if.sv
// Conv-2 read port and P2 write port of the pooling-2 stage.
interface p2_pool_write_if import cnn_pkg::*; ();

  logic              c2_rd_en;
  logic [CH_W-1:0]   c2_ch;
  logic [C2_AW-1:0]  c2_addr;
  data_t             c2_data;
  logic              p2_we;
  logic [CH_W-1:0]   p2_ch;
  logic [P2_AW-1:0]  p2_addr;
  data_t             p2_wdata;

  modport master (
    output c2_rd_en, c2_ch, c2_addr, p2_we, p2_ch, p2_addr, p2_wdata,
    input  c2_data
  );

  modport slave (
    input  c2_rd_en, c2_ch, c2_addr, p2_we, p2_ch, p2_addr, p2_wdata,
    output c2_data
  );

endinterface

// File: rtl/p2_pool_write_max_acc.sv
// Signed running maximum: load replaces, update keeps the current value on ties.
module pool_max_acc import cnn_pkg::*; (
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  upd_i,
  input  data_t din_i,
  output data_t max_nxt_c
);

  data_t max_q;
  data_t max_d;

  always_comb begin
    max_d = max_q;
    if (load_i) begin
      max_d = din_i;
    end else if (upd_i && (din_i > max_q)) begin
      max_d = din_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_nxt_c = max_d;

endmodule

// File: rtl/p2_pool_write.sv
// Pooling-2 stage: 2x2/stride-2 signed max-pool of 12 conv-2 maps (8x8) into P2 memory (4x4).
module p2_pool_write import cnn_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  p2_pool_write_if.master bus
);

  pool_state_e       state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [P2_AW-1:0]  pix_q, pix_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic              c2_rd_en_q, c2_rd_en_d;
  logic [CH_W-1:0]   c2_ch_q, c2_ch_d;
  logic [C2_AW-1:0]  c2_addr_q, c2_addr_d;
  logic              p2_we_q, p2_we_d;
  logic [CH_W-1:0]   p2_ch_q, p2_ch_d;
  logic [P2_AW-1:0]  p2_addr_q, p2_addr_d;
  data_t             p2_wdata_q, p2_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc_load;
  logic              acc_upd;
  data_t             max_nxt;

  // Read data lags its strobe by one cycle: tap0 lands in RD/tap1, tap3 lands in LAST.
  assign acc_load = (state_q == RD) && (tap_q == 2'd1);
  assign acc_upd  = ((state_q == RD) && (tap_q >= 2'd2)) || (state_q == LAST);

  pool_max_acc u_max_acc (
    .clk       (clk),
    .reset     (reset),
    .load_i    (acc_load),
    .upd_i     (acc_upd),
    .din_i     (bus.c2_data),
    .max_nxt_c (max_nxt)
  );

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    pix_d   = pix_q;
    ch_d    = ch_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RD;
          tap_d   = '0;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      RD: begin
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'd3) begin
          state_d = LAST;
        end
      end
      LAST: state_d = WR;
      WR: begin
        pix_d   = pix_q + 4'd1;
        state_d = RD;
        if (pix_q == 4'd15) begin
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            state_d = DONE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    c2_rd_en_d = (state_d == RD);
    c2_ch_d    = c2_rd_en_d ? ch_d : '0;
    c2_addr_d  = c2_rd_en_d ? {pix_d[3:2], tap_d[1], pix_d[1:0], tap_d[0]} : '0;
    p2_we_d    = (state_d == WR);
    p2_ch_d    = p2_we_d ? ch_d : '0;
    p2_addr_d  = p2_we_d ? pix_d : '0;
    p2_wdata_d = p2_we_d ? max_nxt : '0;
    busy_d     = (state_d == RD) || (state_d == LAST) || (state_d == WR);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      pix_q      <= '0;
      ch_q       <= '0;
      c2_rd_en_q <= 1'b0;
      c2_ch_q    <= '0;
      c2_addr_q  <= '0;
      p2_we_q    <= 1'b0;
      p2_ch_q    <= '0;
      p2_addr_q  <= '0;
      p2_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      c2_rd_en_q <= c2_rd_en_d;
      c2_ch_q    <= c2_ch_d;
      c2_addr_q  <= c2_addr_d;
      p2_we_q    <= p2_we_d;
      p2_ch_q    <= p2_ch_d;
      p2_addr_q  <= p2_addr_d;
      p2_wdata_q <= p2_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.c2_rd_en = c2_rd_en_q;
  assign bus.c2_ch    = c2_ch_q;
  assign bus.c2_addr  = c2_addr_q;
  assign bus.p2_we    = p2_we_q;
  assign bus.p2_ch    = p2_ch_q;
  assign bus.p2_addr  = p2_addr_q;
  assign bus.p2_wdata = p2_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_p2_pool_write.sv
// Directed bench for p2_pool_write: conv-2 memory model, write scoreboard, timing counters.
module tb_p2_pool_write;
  import cnn_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  p2_pool_write_if bus ();

  p2_pool_write dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  data_t mem [CHANNELS][64];
  data_t cap [CHANNELS][16];

  int n_chk = 0;
  int n_bad = 0;
  int busy_cnt, rd_cnt, wr_cnt, pat_err, ord_err, dat_err, zero_err, both_err;
  bit mon_en = 1'b0;

  bit pend_v   = 1'b0;
  int pend_ch  = 0;
  int pend_addr = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic data_t exp_max(input int ch, input int p);
    int    r0 = 2 * (p / 4);
    int    c0 = 2 * (p % 4);
    data_t m  = mem[ch][r0*8 + c0];
    data_t v;
    for (int k = 1; k < 4; k++) begin
      v = mem[ch][(r0 + k/2)*8 + c0 + k%2];
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Conv-2 memory: data for the strobe seen in one cycle is presented in the next.
  always @(negedge clk) begin
    pend_v    = bus.c2_rd_en;
    pend_ch   = int'(bus.c2_ch);
    pend_addr = int'(bus.c2_addr);
  end

  always @(posedge clk) begin
    #1;
    bus.c2_data = (pend_v && pend_ch < int'(CHANNELS)) ? mem[pend_ch][pend_addr] : '0;
  end

  always @(negedge clk) begin
    int px, k, ech, p, ea;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (busy && done) both_err++;
      if (!busy && (bus.c2_rd_en || bus.p2_we)) zero_err++;
      if (bus.c2_rd_en) begin
        px  = rd_cnt / 4;
        k   = rd_cnt % 4;
        ech = px / 16;
        p   = px % 16;
        ea  = (2*(p/4) + k/2)*8 + 2*(p%4) + k%2;
        if (int'(bus.c2_ch) != ech || int'(bus.c2_addr) != ea) pat_err++;
        rd_cnt++;
      end else if (bus.c2_ch != '0 || bus.c2_addr != '0) begin
        zero_err++;
      end
      if (bus.p2_we) begin
        ech = wr_cnt / 16;
        p   = wr_cnt % 16;
        if (int'(bus.p2_ch) != ech || int'(bus.p2_addr) != p) ord_err++;
        if (wr_cnt < 192) begin
          if (bus.p2_wdata != exp_max(ech, p)) dat_err++;
          cap[ech][p] = bus.p2_wdata;
        end
        wr_cnt++;
      end else if (bus.p2_ch != '0 || bus.p2_addr != '0 || bus.p2_wdata != '0) begin
        zero_err++;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     longint'(busy),         0);
    chk({tag, "_done"},     longint'(done),         0);
    chk({tag, "_rd_en"},    longint'(bus.c2_rd_en), 0);
    chk({tag, "_c2_ch"},    longint'(bus.c2_ch),    0);
    chk({tag, "_c2_addr"},  longint'(bus.c2_addr),  0);
    chk({tag, "_we"},       longint'(bus.p2_we),    0);
    chk({tag, "_p2_ch"},    longint'(bus.p2_ch),    0);
    chk({tag, "_p2_addr"},  longint'(bus.p2_addr),  0);
    chk({tag, "_p2_wdata"}, longint'(bus.p2_wdata), 0);
  endtask

  // Caller sits just after a falling edge; c counts rising edges after the one sampling start.
  task automatic run_pass(input bit hold);
    int done_cyc;
    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    pat_err = 0; ord_err = 0; dat_err = 0; zero_err = 0; both_err = 0;
    mon_en   = 1'b1;
    done_cyc = -1;
    start    = 1'b1;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("first_busy",  longint'(busy),         1);
        chk("first_done",  longint'(done),         0);
        chk("first_rd_en", longint'(bus.c2_rd_en), 1);
        chk("first_c2_ch", longint'(bus.c2_ch),    0);
        chk("first_addr",  longint'(bus.c2_addr),  0);
        if (!hold) start = 1'b0;
      end
      if (c == 1100) start = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    mon_en = 1'b0;
    chk("done_edge",  done_cyc, 1152);
    chk("busy_cyc",   busy_cnt, 1152);
    chk("rd_strobes", rd_cnt,   768);
    chk("wr_pulses",  wr_cnt,   192);
    chk("rd_pattern", pat_err,  0);
    chk("wr_order",   ord_err,  0);
    chk("wr_data",    dat_err,  0);
    chk("idle_zero",  zero_err, 0);
    chk("busy_done",  both_err, 0);
  endtask

  initial begin
    bus.c2_data = '0;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (ch == 0) begin
            mem[ch][r*8+c] = data_t'(r*8 + c);
          end else if (ch == 1) begin
            mem[ch][r*8+c] = (r == 1 && c == 0) ? data_t'(-3) : data_t'(-100);
          end else if (ch == 2) begin
            // Window maximum sits at tap0, with tap1 tying it.
            if (r % 2 == 0) mem[ch][r*8+c] = data_t'(-20 + (r/2)*4 + c/2);
            else            mem[ch][r*8+c] = data_t'(-50);
          end else begin
            mem[ch][r*8+c] = data_t'($urandom);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", longint'(busy), 0);

    // Abort a run with an asynchronous reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    chk("mid_busy", longint'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("areset");
    @(posedge clk);
    #1 chk_all_zero("rst_next");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_done", longint'(done), 0);

    // Fresh pass with start held high while busy.
    run_pass(1'b1);
    chk("ch0_pix0",  longint'(cap[0][0]),  9);
    chk("ch0_pix15", longint'(cap[0][15]), 63);
    chk("ch1_pix0",  longint'(cap[1][0]),  -3);
    chk("ch1_pix9",  longint'(cap[1][9]),  -100);
    chk("ch2_pix6",  longint'(cap[2][6]),  -14);
    chk("ch2_pix15", longint'(cap[2][15]), -5);

    repeat (5) @(negedge clk);
    chk("hold_done",  longint'(done),         1);
    chk("hold_busy",  longint'(busy),         0);
    chk("hold_rd_en", longint'(bus.c2_rd_en), 0);

    // Restart from DONE with a one-cycle start pulse.
    run_pass(1'b0);
    chk("rerun_ch0_pix5", longint'(cap[0][5]), 27);
    repeat (3) @(negedge clk);
    chk("end_busy", longint'(busy), 0);
    chk("end_done", longint'(done), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
